// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ssd_pkg
// Brief    : Shared 7-segment definitions (patterns, digit slots, helpers).
// Revision : 1.0 - initial release
// ============================================================================
package ssd_pkg;

    localparam int DIGITS       = 4;
    localparam int DIG_SEC_ONES = 0;
    localparam int DIG_SEC_TENS = 1;
    localparam int DIG_MIN_ONES = 2;
    localparam int DIG_MIN_TENS = 3;

    typedef logic [3:0] bcd_t;

    // Patterns are g..a, active-high.
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } cap_state_t;

    function automatic logic [1:0] onehot_idx(input logic [DIGITS-1:0] sel);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (sel[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [6:0] bcd_pair_bin(input bcd_t tens, input bcd_t ones);
        return (7'(tens) * 7'd10) + 7'(ones);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_decode
// Brief    : Combinational 7-segment pattern to {BCD digit, invalid} decoder.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_decode
    import ssd_pkg::*;
(
    input  logic [6:0] i_seg,
    output bcd_t       o_digit,
    output logic       o_invalid
);

    always_comb begin
        o_digit   = 4'd0;
        o_invalid = 1'b0;
        case (i_seg)
            SEG_0:   o_digit = 4'd0;
            SEG_1:   o_digit = 4'd1;
            SEG_2:   o_digit = 4'd2;
            SEG_3:   o_digit = 4'd3;
            SEG_4:   o_digit = 4'd4;
            SEG_5:   o_digit = 4'd5;
            SEG_6:   o_digit = 4'd6;
            SEG_7:   o_digit = 4'd7;
            SEG_8:   o_digit = 4'd8;
            SEG_9:   o_digit = 4'd9;
            default: o_invalid = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seven_seg_capture.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_capture
// Brief    : Reconstructs the MM:SS value shown on a multiplexed 4-digit
//            7-segment display from its seg/dp/an pins.
//            SEVEN_SEG_CAPTURE_BIN_EN adds binary sec_bin/min_bin outputs.
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_capture
    import ssd_pkg::*;
#(
    parameter int STABLE_CYCLES  = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_in,
    input  logic        dp_in,
    input  logic [3:0]  an_in,
    output logic [15:0] bcd_out,
    output logic [3:0]  dp_out,
    output logic        frame_valid,
    output logic        frame_err
`ifdef SEVEN_SEG_CAPTURE_BIN_EN
    ,
    output logic [5:0]  sec_bin,
    output logic [5:0]  min_bin
`endif
);

    localparam int                 c_cnt_w    = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_stable   = c_cnt_w'(STABLE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [6:0]         c_seg_idle = {7{SEG_ACTIVE_LOW}};
    localparam logic               c_dp_idle  = SEG_ACTIVE_LOW;
    localparam logic [3:0]         c_an_idle  = {4{AN_ACTIVE_LOW}};

    logic [6:0]         r_seg_s1, r_seg_s2, r_prev_seg, w_seg;
    logic               r_dp_s1, r_dp_s2, r_prev_dp, w_dp;
    logic [3:0]         r_an_s1, r_an_s2, r_prev_an, w_an;
    logic               w_changed, w_onehot, w_capture, w_frame_done;
    logic [1:0]         w_idx;
    bcd_t               w_dec_digit;
    logic               w_dec_inv;
    cap_state_t         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    bcd_t               r_slot_bcd [DIGITS];
    logic [DIGITS-1:0]  r_slot_dp, r_slot_inv, r_mask;
    logic [15:0]        r_bcd_out;
    logic [3:0]         r_dp_out;
    logic               r_frame_valid, r_frame_err, w_bin_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_s1 <= c_seg_idle;
            r_seg_s2 <= c_seg_idle;
            r_dp_s1  <= c_dp_idle;
            r_dp_s2  <= c_dp_idle;
            r_an_s1  <= c_an_idle;
            r_an_s2  <= c_an_idle;
        end else begin
            r_seg_s1 <= seg_in;
            r_seg_s2 <= r_seg_s1;
            r_dp_s1  <= dp_in;
            r_dp_s2  <= r_dp_s1;
            r_an_s1  <= an_in;
            r_an_s2  <= r_an_s1;
        end
    end

    assign w_seg = r_seg_s2 ^ c_seg_idle;
    assign w_dp  = r_dp_s2 ^ c_dp_idle;
    assign w_an  = r_an_s2 ^ c_an_idle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_seg <= '0;
            r_prev_dp  <= 1'b0;
            r_prev_an  <= '0;
        end else begin
            r_prev_seg <= w_seg;
            r_prev_dp  <= w_dp;
            r_prev_an  <= w_an;
        end
    end

    assign w_changed = (w_seg != r_prev_seg) || (w_dp != r_prev_dp) || (w_an != r_prev_an);
    assign w_onehot  = (w_an != 4'd0) && ((w_an & (w_an - 4'd1)) == 4'd0);
    assign w_capture = (r_state == ST_SETTLE) && !w_changed && (r_cnt == c_stable);
    assign w_idx     = onehot_idx(w_an);

    seg7_decode u_decode (
        .i_seg     (w_seg),
        .o_digit   (w_dec_digit),
        .o_invalid (w_dec_inv)
    );

    // Counter saturates at c_stable: HOLD keeps it there without recapturing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_WAIT;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_SETTLE, ST_HOLD: begin
                    if (w_changed) begin
                        if (w_onehot) begin
                            r_state <= ST_SETTLE;
                            r_cnt   <= c_cnt_one;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= '0;
                        end
                    end else if (r_state == ST_SETTLE) begin
                        if (r_cnt == c_stable) begin
                            r_state <= ST_HOLD;
                        end else begin
                            r_cnt <= r_cnt + c_cnt_one;
                        end
                    end
                end
                default: begin
                    if (w_onehot) begin
                        r_state <= ST_SETTLE;
                        r_cnt   <= c_cnt_one;
                    end else begin
                        r_state <= ST_WAIT;
                        r_cnt   <= '0;
                    end
                end
            endcase
        end
    end

    assign w_frame_done = (r_mask == 4'hF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) r_slot_bcd[i] <= '0;
            r_slot_dp     <= '0;
            r_slot_inv    <= '0;
            r_mask        <= '0;
            r_bcd_out     <= '0;
            r_dp_out      <= '0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_frame_valid <= w_frame_done;
            if (w_frame_done) begin
                r_bcd_out   <= {r_slot_bcd[DIG_MIN_TENS], r_slot_bcd[DIG_MIN_ONES],
                                r_slot_bcd[DIG_SEC_TENS], r_slot_bcd[DIG_SEC_ONES]};
                r_dp_out    <= r_slot_dp;
                r_frame_err <= (|r_slot_inv) | w_bin_err;
                r_slot_inv  <= '0;
            end
            // A capture landing on the frame cycle still wins its own slot bit.
            if (w_capture) begin
                r_slot_bcd[w_idx] <= w_dec_digit;
                r_slot_dp[w_idx]  <= w_dp;
                r_slot_inv[w_idx] <= w_dec_inv;
            end
            r_mask <= (w_frame_done ? 4'h0 : r_mask) | (w_capture ? w_an : 4'h0);
        end
    end

`ifdef SEVEN_SEG_CAPTURE_BIN_EN
    logic [6:0] w_sec_raw, w_min_raw;
    logic [5:0] r_sec_bin, r_min_bin;

    assign w_sec_raw = bcd_pair_bin(r_slot_bcd[DIG_SEC_TENS], r_slot_bcd[DIG_SEC_ONES]);
    assign w_min_raw = bcd_pair_bin(r_slot_bcd[DIG_MIN_TENS], r_slot_bcd[DIG_MIN_ONES]);
    assign w_bin_err = (w_sec_raw > 7'd59) || (w_min_raw > 7'd59);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sec_bin <= '0;
            r_min_bin <= '0;
        end else if (w_frame_done) begin
            r_sec_bin <= (w_sec_raw > 7'd59) ? 6'd59 : w_sec_raw[5:0];
            r_min_bin <= (w_min_raw > 7'd59) ? 6'd59 : w_min_raw[5:0];
        end
    end

    assign sec_bin = r_sec_bin;
    assign min_bin = r_min_bin;
`else
    assign w_bin_err = 1'b0;
`endif

    assign bcd_out     = r_bcd_out;
    assign dp_out      = r_dp_out;
    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_capture
// Brief    : Self-checking bench for seven_seg_capture (STABLE_CYCLES=4,
//            active-low pins); covers SEVEN_SEG_CAPTURE_BIN_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_capture;

    localparam int S = 4;
    localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    typedef struct packed {
        logic [15:0] bcd;
        logic [3:0]  dp;
        logic        err;
        logic [5:0]  sb;
        logic [5:0]  mb;
    } frame_t;

    typedef struct {
        logic [3:0][6:0] pats;
        logic [3:0]      dp;
        logic [15:0]     bcd;
        logic            inv;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic        dp_in;
    logic [3:0]  an_in;
    logic [15:0] bcd_out;
    logic [3:0]  dp_out;
    logic        frame_valid, frame_err;
`ifdef SEVEN_SEG_CAPTURE_BIN_EN
    logic [5:0]  sec_bin, min_bin;
`endif

    int     n_checks = 0;
    int     n_fail   = 0;
    frame_t obs[$];
    frame_t exp_q[$];

    always #5 clk = ~clk;

    seven_seg_capture #(
        .STABLE_CYCLES  (S),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .dp_in       (dp_in),
        .an_in       (an_in),
        .bcd_out     (bcd_out),
        .dp_out      (dp_out),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
`ifdef SEVEN_SEG_CAPTURE_BIN_EN
        ,
        .sec_bin     (sec_bin),
        .min_bin     (min_bin)
`endif
    );

    function automatic frame_t cur_frame();
        frame_t f;
        f = '{bcd: bcd_out, dp: dp_out, err: frame_err, sb: 6'd0, mb: 6'd0};
`ifdef SEVEN_SEG_CAPTURE_BIN_EN
        f.sb = sec_bin;
        f.mb = min_bin;
`endif
        return f;
    endfunction

    always @(negedge clk) begin
        if (rst_n && frame_valid) obs.push_back(cur_frame());
    end

    // Expected frame straight from the displayed digits.
    function automatic frame_t mk_frame(input logic [15:0] bcd, input logic [3:0] dp,
                                        input logic inv);
        frame_t f;
        f = '{bcd: bcd, dp: dp, err: inv, sb: 6'd0, mb: 6'd0};
`ifdef SEVEN_SEG_CAPTURE_BIN_EN
        begin
            int s, m;
            s = int'(bcd[7:4]) * 10 + int'(bcd[3:0]);
            m = int'(bcd[15:12]) * 10 + int'(bcd[11:8]);
            if (s > 59) begin s = 59; f.err = 1'b1; end
            if (m > 59) begin m = 59; f.err = 1'b1; end
            f.sb = 6'(s);
            f.mb = 6'(m);
        end
`endif
        return f;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int pos, input logic [6:0] pat, input logic dp);
        case (pos)
            0, 1, 2, 3: an_in = ~(4'b0001 << pos);
            4:          an_in = 4'b1111;
            default:    an_in = 4'b1100;
        endcase
        seg_in = ~pat;
        dp_in  = ~dp;
    endtask

    task automatic show(input int pos, input logic [6:0] pat, input logic dp, input int hold);
        drive(pos, pat, dp);
        repeat (hold) @(negedge clk);
    endtask

    task automatic do_reset();
        drive(4, 7'h00, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        obs.delete();
    endtask

    vec_t        vecs [7];
    int          lat;
    frame_t      ef;
    logic [3:0]  m_bcd [4];
    logic [3:0]  m_dp, m_inv, m_mask;

    initial begin
        vecs[0] = '{pats: {7'h06, 7'h5B, 7'h4F, 7'h66}, dp: 4'b0000, bcd: 16'h1234, inv: 1'b0};
        vecs[1] = '{pats: {7'h6D, 7'h49, 7'h07, 7'h7F}, dp: 4'b0000, bcd: 16'h5078, inv: 1'b1};
        vecs[2] = '{pats: {7'h6D, 7'h6F, 7'h6D, 7'h6F}, dp: 4'b1010, bcd: 16'h5959, inv: 1'b0};
        vecs[3] = '{pats: {7'h3F, 7'h3F, 7'h3F, 7'h3F}, dp: 4'b0101, bcd: 16'h0000, inv: 1'b0};
        vecs[4] = '{pats: {7'h3F, 7'h07, 7'h66, 7'h6D}, dp: 4'b0000, bcd: 16'h0745, inv: 1'b0};
        vecs[5] = '{pats: {7'h6F, 7'h4F, 7'h5B, 7'h06}, dp: 4'b1111, bcd: 16'h9321, inv: 1'b0};
        vecs[6] = '{pats: {7'h06, 7'h4F, 7'h7D, 7'h00}, dp: 4'b0010, bcd: 16'h1360, inv: 1'b1};

        drive(4, 7'h00, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        do_reset();
        check("rst_bcd", bcd_out, 16'h0);
        check("rst_dp", dp_out, 4'h0);
        check("rst_fv", frame_valid, 1'b0);
        check("rst_err", frame_err, 1'b0);
`ifdef SEVEN_SEG_CAPTURE_BIN_EN
        check("rst_bin", {sec_bin, min_bin}, 12'h0);
`endif

        for (int v = 0; v < 7; v++) begin
            for (int p = 0; p < 4; p++) show(p, vecs[v].pats[p], vecs[v].dp[p], 10);
            show(4, 7'h00, 1'b0, 6);
            ef = mk_frame(vecs[v].bcd, vecs[v].dp, vecs[v].inv);
            check("tbl_count", obs.size(), 1);
            if (obs.size() > 0) check("tbl_frame", obs[0], ef);
            check("tbl_fv_low", frame_valid, 1'b0);
            check("tbl_hold_bcd", bcd_out, vecs[v].bcd);
            obs.delete();
        end

        // Glitch on slot 0, then last-digit latency
        do_reset();
        show(0, 7'h06, 1'b0, 3);
        show(0, 7'h5B, 1'b0, 10);
        show(1, 7'h3F, 1'b0, 10);
        show(2, 7'h3F, 1'b0, 10);
        drive(3, 7'h3F, 1'b0);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (frame_valid) begin
                lat = n;
                break;
            end
        end
        check("latency", lat, S + 4);
        @(negedge clk);
        show(4, 7'h00, 1'b0, 8);
        check("glitch_count", obs.size(), 1);
        if (obs.size() > 0) check("glitch_frame", obs[0], mk_frame(16'h0002, 4'h0, 1'b0));

        // Reset mid-frame, then fill slots in reverse order
        show(0, 7'h6F, 1'b0, 10);
        show(1, 7'h6D, 1'b0, 10);
        show(2, 7'h6F, 1'b0, 10);
        drive(4, 7'h00, 1'b0);
        #2 rst_n = 1'b0;
        #1 check("async_rst_bcd", bcd_out, 16'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        obs.delete();
        show(3, 7'h6D, 1'b0, 10);
        show(2, 7'h6F, 1'b0, 10);
        show(1, 7'h6D, 1'b0, 10);
        show(0, 7'h6F, 1'b0, 10);
        show(4, 7'h00, 1'b0, 8);
        check("midrst_count", obs.size(), 1);
        if (obs.size() > 0) check("midrst_frame", obs[0], mk_frame(16'h5959, 4'h0, 1'b0));

        // Non-one-hot anodes must never capture
        do_reset();
        show(5, 7'h06, 1'b0, 50);
        show(4, 7'h06, 1'b0, 50);
        check("multi_hot_count", obs.size(), 0);
        show(0, 7'h3F, 1'b0, 10);
        show(1, 7'h3F, 1'b0, 10);
        show(2, 7'h3F, 1'b0, 10);
        show(4, 7'h00, 1'b0, 10);
        check("no_stray_mask", obs.size(), 0);

        // Randomized presentations against a sequence-level model
        do_reset();
        exp_q.delete();
        m_mask = 4'h0;
        m_inv  = 4'h0;
        m_dp   = 4'h0;
        for (int i = 0; i < 4; i++) m_bcd[i] = 4'h0;
        begin
            int pos, ppos, hold, r, dig;
            logic [6:0] pat, ppat;
            logic dp, pdp, inv;
            ppos = 4; ppat = 7'h00; pdp = 1'b0;
            for (int k = 0; k < 300; k++) begin
                r   = int'($urandom_range(0, 9));
                pos = (r < 8) ? (r % 4) : ((r == 8) ? 4 : 5);
                if ($urandom_range(0, 4) != 0) pat = SEG_TAB[$urandom_range(0, 9)];
                else                           pat = 7'($urandom);
                dp = 1'($urandom);
                if (pos == ppos && pat == ppat && dp == pdp) pos = (pos + 1) % 6;
                hold = ($urandom_range(0, 1) == 1) ? int'($urandom_range(S + 2, 12))
                                                   : int'($urandom_range(1, S - 1));
                if (hold >= S + 2 && pos < 4) begin
                    dig = 0;
                    inv = 1'b1;
                    for (int d = 0; d < 10; d++) begin
                        if (SEG_TAB[d] == pat) begin
                            dig = d;
                            inv = 1'b0;
                        end
                    end
                    m_bcd[pos]  = 4'(dig);
                    m_dp[pos]   = dp;
                    m_inv[pos]  = inv;
                    m_mask[pos] = 1'b1;
                    if (m_mask == 4'hF) begin
                        exp_q.push_back(mk_frame({m_bcd[3], m_bcd[2], m_bcd[1], m_bcd[0]},
                                                 m_dp, |m_inv));
                        m_mask = 4'h0;
                        m_inv  = 4'h0;
                    end
                end
                show(pos, pat, dp, hold);
                ppos = pos; ppat = pat; pdp = dp;
            end
        end
        show(4, 7'h00, 1'b0, 12);
        check("rand_count", obs.size(), exp_q.size());
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            check("rand_frame", obs[i], exp_q[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
